rmw_counter_bank: RTL
=====================

# rmw_counter_bank

Initiator-side read-modify-write engine that owns a DEPTH x WIDTH counter memory and drives the read/conditional-write sequence on it. Clients issue single commands over a valid/ready request channel (read, increment, add, clear), and the engine returns the pre-modification value on a valid/ready response channel. It sits between client logic and the counter storage so that no client ever touches memory read/write enables directly. One command is outstanding at a time; after reset the memory is zeroed by an internal sweep.

## Interface
- WIDTH, 32, data/counter width in bits
- DEPTH, 8, number of entries; power of two, >= 2
- AW, log2(DEPTH) = 3, address width (derived, not overridable)

- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- io_cmd_valid  input  1  request present
- io_cmd_ready  output  1  engine can accept a request this cycle
- io_cmd_addr  input  AW  target entry
- io_cmd_op  input  2  00 READ, 01 INC, 10 ADD, 11 CLEAR
- io_cmd_data  input  WIDTH  operand for ADD; ignored otherwise
- io_resp_valid  output  1  response present
- io_resp_ready  input  1  consumer takes response this cycle
- io_resp_data  output  WIDTH  entry value before the command's write
- io_init_done  output  1  high once the post-reset zeroing sweep has finished

## Operation
- Storage: DEPTH x WIDTH array, single read port with registered (1-cycle) data, single write port; at most one write per cycle.
- States: INIT, IDLE, EXEC, RESP.
- INIT: entered on reset. Index counter starts at 0; each cycle writes 0 to mem[index], index += 1. After writing DEPTH-1, go to IDLE and set io_init_done (sticky until next reset). io_cmd_ready = 0 throughout.
- IDLE: io_cmd_ready = 1. On io_cmd_valid & io_cmd_ready: latch addr/op/data, issue a read of mem[addr], go to EXEC. Otherwise stay.
- EXEC (one cycle): old = read data. New value: READ -> no write; INC -> old + 1; ADD -> old + io_cmd_data (as latched); CLEAR -> 0. Perform the write (except READ), register old into the response register, go to RESP.
- RESP: io_resp_valid = 1, io_resp_data = old; both held stable until io_resp_ready. On io_resp_ready, go to IDLE.
- Arithmetic is modulo 2^WIDTH; carry out is discarded (0xFFFFFFFF + 1 = 0).
- Address is used as given (AW bits); no out-of-range case exists.
- A command to the same address as the previous one observes the previous write (the write completes in EXEC, before the next read can be issued in IDLE).

## Timing
- Reset values: io_cmd_ready 0, io_resp_valid 0, io_resp_data 0, io_init_done 0.
- INIT lasts exactly DEPTH cycles after reset deasserts; io_cmd_ready first rises in cycle DEPTH (counting the first post-reset cycle as 0).
- Accept at cycle t -> write at t+1 -> io_resp_valid at t+2. With io_resp_ready held high, the next accept is at t+3 (minimum 3 cycles per command).
- io_cmd_ready is 0 in EXEC and RESP; command inputs are sampled only at the accept edge.
- Response backpressure: RESP holds indefinitely; no further command is accepted.
- Reset asserted in any state (including mid-EXEC or with a response pending): the pending response is dropped, outputs return to reset values next cycle, and INIT restarts from index 0. Any write in the reset cycle is suppressed.
- io_cmd_valid during INIT is ignored (not queued).

## Test plan
- Reset, hold reset 2 cycles, release -> io_cmd_ready low exactly 8 cycles, then high with io_init_done = 1; READ of every address returns 0.
- INC addr 3 three times, then READ addr 3 -> responses 0, 1, 2, then 3; each response arrives 2 cycles after accept.
- ADD addr 5 data 0xFFFFFFFF, then INC addr 5, then READ -> responses 0, 0xFFFFFFFF, then 0 (wrap).
- Issue INC addr 2, hold io_resp_ready low 5 cycles -> io_resp_valid and data 0 stable, io_cmd_ready stays 0 with io_cmd_valid high; after ready, next command accepted the following cycle.
- CLEAR addr 7 after setting it to 9 -> response 9, subsequent READ returns 0; other entries unchanged.
- Assert reset while in RESP with addr 1 = 4 -> io_resp_valid drops, INIT reruns 8 cycles, READ addr 1 returns 0.

Source files
------------

// File: rtl/rmw_counter_bank.sv
// Read-modify-write engine over a DEPTH x WIDTH counter memory, zeroed by a post-reset sweep.
// Latency: accept -> response valid 2 cycles later; response held until io_resp_ready; one command in flight.
module rmw_counter_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [AW-1:0]    io_cmd_addr,
  input  logic [1:0]       io_cmd_op,
  input  logic [WIDTH-1:0] io_cmd_data,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [WIDTH-1:0] io_resp_data,
  output logic             io_init_done
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    addr_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] resp_q;
  logic             done_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign accept = io_cmd_valid && io_cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: if (io_cmd_valid) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (io_resp_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    io_cmd_ready  = 1'b0;
    io_resp_valid = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = addr_q;
    mem_wdata     = '0;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
      end
      S_IDLE: io_cmd_ready = 1'b1;
      S_EXEC: begin
        mem_we = (op_q != OP_READ);
        case (op_q)
          OP_INC:   mem_wdata = rd_q + WIDTH'(1);
          OP_ADD:   mem_wdata = rd_q + data_q;
          OP_CLEAR: mem_wdata = '0;
          default:  mem_wdata = rd_q;
        endcase
      end
      S_RESP: io_resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command fields are captured only at the accept edge; the read is issued in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      op_q   <= OP_READ;
      data_q <= '0;
      rd_q   <= '0;
      resp_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= io_cmd_addr;
        op_q   <= io_cmd_op;
        data_q <= io_cmd_data;
        rd_q   <= mem_q[io_cmd_addr];
      end
      if (state_q == S_EXEC) resp_q <= rd_q;
      if (state_q == S_INIT && state_d == S_IDLE) done_q <= 1'b1;
    end
  end

  // Storage has no reset of its own; the INIT sweep zeroes it and reset blocks any pending write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign io_resp_data = resp_q;
  assign io_init_done = done_q;

endmodule
